// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Prioritised, maskable interrupt controller for the MiniSRC processor.
//   Rising edges on irq_in are latched as pending bits. The lowest-index
//   pending and unmasked line wins. A request is raised to the control unit
//   with a frozen id/vector. On acknowledge the line moves to in-service until
//   end-of-interrupt. There is no nesting.
//
//   Optional build macro:
//     IRQ_SYNC_EN  adds a two-flop synchroniser on every irq_in line ahead of
//                  edge detection. This adds 2 cycles of irq_in->pending
//                  latency. When undefined, irq_in must be synchronous to
//                  Clock.
//
//   Ports:
//     Clock       system clock, posedge
//     Reset       synchronous, active-high
//     irq_in      raw interrupt lines, rising-edge triggered
//     mask_we     mask register write enable
//     mask_wdata  new mask (1 = enabled)
//     ien         global interrupt enable
//     int_ack     control unit accepts the current request (pulse)
//     eoi         end of interrupt (pulse)
//     int_req     request to the control unit
//     int_id      id of the requested / in-service line
//     int_vector  VECTOR_BASE + int_id*VECTOR_STRIDE
//     pending     latched pending bits
//     mask        current mask register
//     in_service  an interrupt is being serviced
module interrupt_controller #(
  parameter int unsigned NUM_IRQ       = 8,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter int unsigned VECTOR_STRIDE = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ien,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic [3:0]         int_id,
  output logic [31:0]        int_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               in_service
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [3:0]         id_q, id_d;
  logic [31:0]        vector_q, vector_d;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] eligible;
  logic               win_found;
  logic [3:0]         win_id;
  logic [31:0]        win_vector;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign irq_rise = irq_s & ~irq_prev_q;
  assign eligible = pending_q & mask_q;

  // Lowest index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && !win_found) begin
        win_found = 1'b1;
        win_id    = 4'(i);
      end
    end
    win_vector = VECTOR_BASE + 32'(win_id) * 32'(VECTOR_STRIDE);
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | irq_rise;
    mask_d     = mask_we ? mask_wdata : mask_q;
    irq_prev_d = irq_s;
    id_d       = id_q;
    vector_d   = vector_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ien && win_found) begin
          state_d  = ST_REQ;
          id_d     = win_id;
          vector_d = win_vector;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          // An edge arriving on the acknowledged line in the same cycle re-pends it.
          for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (4'(i) == id_q) pending_d[i] = irq_rise[i];
          end
          state_d = ST_SERVICE;
        end else if (!ien) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      id_q       <= '0;
      vector_q   <= VECTOR_BASE;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_prev_d;
      id_q       <= id_d;
      vector_q   <= vector_d;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign int_id     = id_q;
  assign int_vector = vector_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int N = 8;
  localparam logic [31:0] VB = 32'h0000_0100;
`ifdef IRQ_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         ien = 1'b0;
  logic         int_ack = 1'b0;
  logic         eoi = 1'b0;
  logic         int_req;
  logic [3:0]   int_id;
  logic [31:0]  int_vector;
  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic         in_service;

  int n_vec = 0;
  int n_err = 0;

  interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(VB), .VECTOR_STRIDE(4)) dut (
    .Clock(Clock), .Reset(Reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ien(ien), .int_ack(int_ack), .eoi(eoi),
    .int_req(int_req), .int_id(int_id), .int_vector(int_vector),
    .pending(pending), .mask(mask), .in_service(in_service)
  );

  always #5 Clock = ~Clock;

  // Reference model: mode 0 = waiting, 1 = requesting, 2 = servicing.
  int           m_mode = 0;
  int           m_id = 0;
  bit [N-1:0]   m_pend = '0;
  bit [N-1:0]   m_mask = '0;
  bit [N-1:0]   m_last = '0;
  bit [N-1:0]   m_s1 = '0;
  bit [N-1:0]   m_s2 = '0;

  task automatic model_step();
    bit [N-1:0] seen, rises, elig;
`ifdef IRQ_SYNC_EN
    seen = m_s2;
`else
    seen = irq_in;
`endif
    if (Reset) begin
      m_mode = 0; m_id = 0; m_pend = '0; m_mask = '0; m_last = '0;
      m_s1 = '0; m_s2 = '0;
      return;
    end
    rises = seen & ~m_last;
    elig  = m_pend & m_mask;
    m_pend = m_pend | rises;
    if (m_mode == 0) begin
      if (ien && elig != 0) begin
        m_id = 0;
        while (!elig[m_id]) m_id++;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (int_ack) begin
        m_pend[m_id] = rises[m_id];
        m_mode = 2;
      end else if (!ien) m_mode = 0;
    end else begin
      if (eoi) m_mode = 0;
    end
    if (mask_we) m_mask = mask_wdata;
    m_last = seen;
    m_s2 = m_s1;
    m_s1 = irq_in;
  endtask

  task automatic check(input string tag);
    logic [53:0] obs, exp;
    obs = {int_req, int_id, int_vector, pending, mask, in_service};
    exp = {m_mode == 1, 4'(m_id), VB + 32'(m_id) * 32'd4, m_pend, m_mask, m_mode == 2};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h (req,id,vec,pend,mask,isr)", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clock);
    model_step();
    #1;
    check(tag);
  endtask

  // Ticks until int_req rises (bounded); returns cycles taken.
  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (int_req !== 1'b1 && n < 12) begin
      tick(tag);
      n++;
    end
    expect_val({tag, "_req_seen"}, {31'd0, int_req}, 32'd1);
  endtask

  initial begin
    int n;
    // 1: reset, enable all, single edge on line 3
    tick("reset");
    Reset = 1'b0;
    expect_val("rst_vector", int_vector, VB);
    expect_val("rst_req", {31'd0, int_req}, 32'd0);
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick("mask_ff");
    mask_we = 1'b0; ien = 1'b1; irq_in[3] = 1'b1;
    wait_req("t1", n);
    irq_in = '0;
    expect_val("t1_latency", n, EXP_LAT);
    expect_val("t1_id", {28'd0, int_id}, 32'd3);
    expect_val("t1_vec", int_vector, 32'h10C);
    int_ack = 1'b1; tick("t1_ack"); int_ack = 1'b0;
    expect_val("t1_isr", {31'd0, in_service}, 32'd1);
    eoi = 1'b1; tick("t1_eoi"); eoi = 1'b0;

    // 2: simultaneous edges on 5 and 1
    irq_in = 8'b0010_0010;
    wait_req("t2a", n);
    irq_in = '0;
    expect_val("t2_id1", {28'd0, int_id}, 32'd1);
    int_ack = 1'b1; tick("t2_ack"); int_ack = 1'b0;
    eoi = 1'b1; tick("t2_eoi"); eoi = 1'b0;
    wait_req("t2b", n);
    expect_val("t2_id5", {28'd0, int_id}, 32'd5);
    expect_val("t2_vec", int_vector, 32'h114);
    int_ack = 1'b1; tick("t2_ack5"); int_ack = 1'b0;
    eoi = 1'b1; tick("t2_eoi5"); eoi = 1'b0;

    // 3: masked line stays pending until enabled
    mask_we = 1'b1; mask_wdata = 8'h00; tick("t3_mask0"); mask_we = 1'b0;
    irq_in[2] = 1'b1; tick("t3_irq"); irq_in = '0;
    repeat (4) tick("t3_hold");
    expect_val("t3_pend", {24'd0, pending}, 32'h04);
    expect_val("t3_noreq", {31'd0, int_req}, 32'd0);
    mask_we = 1'b1; mask_wdata = 8'h04; tick("t3_mask4"); mask_we = 1'b0;
    wait_req("t3", n);
    expect_val("t3_id", {28'd0, int_id}, 32'd2);

    // 4: withdraw on ien drop, reissue on raise
    ien = 1'b0; tick("t4_drop");
    expect_val("t4_noreq", {31'd0, int_req}, 32'd0);
    expect_val("t4_pend", {24'd0, pending}, 32'h04);
    ien = 1'b1;
    wait_req("t4", n);
    expect_val("t4_id", {28'd0, int_id}, 32'd2);
    int_ack = 1'b1; tick("t4_ack"); int_ack = 1'b0;
    eoi = 1'b1; tick("t4_eoi"); eoi = 1'b0;
    mask_we = 1'b1; mask_wdata = 8'hFF; tick("t4_mask"); mask_we = 1'b0;

    // 5: re-pend of in-service line, no nesting
    irq_in[0] = 1'b1; tick("t5_irq"); irq_in = '0;
    wait_req("t5a", n);
    int_ack = 1'b1; tick("t5_ack"); int_ack = 1'b0;
    irq_in[0] = 1'b1; tick("t5_irq2"); irq_in = '0;
    repeat (5) tick("t5_hold");
    expect_val("t5_pend0", {31'd0, pending[0]}, 32'd1);
    expect_val("t5_noreq", {31'd0, int_req}, 32'd0);
    eoi = 1'b1; tick("t5_eoi"); eoi = 1'b0;
    wait_req("t5b", n);
    expect_val("t5_id", {28'd0, int_id}, 32'd0);

    // 6: reset during service
    int_ack = 1'b1; tick("t6_ack"); int_ack = 1'b0;
    Reset = 1'b1; tick("t6_rst"); Reset = 1'b0;
    expect_val("t6_state", {in_service, int_req, int_id, pending, mask},
               32'd0);
    expect_val("t6_vec", int_vector, VB);

    // Randomised traffic against the model
    for (int c = 0; c < 2000; c++) begin
      irq_in     = N'($urandom_range(0, 255) & $urandom_range(0, 255));
      ien        = ($urandom_range(0, 7) != 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = N'($urandom_range(0, 255));
      int_ack    = int_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      Reset      = ($urandom_range(0, 199) == 0);
      tick("rand");
    end
    Reset = 1'b0; int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; irq_in = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
